ddr_rw_scheduler: RTL and testbench

- Shares the single DDR3 AXI master between the write path and the read path. The write path is the output of the multichannel write arbiter; the read path is the output of the multichannel read arbiter.
- Serializes bursts and batches same-direction bursts to limit read/write bus turnarounds.
- Bounds starvation of the opposite direction with a batch limit.
- Inserts a programmable turnaround gap whenever the direction changes.

---
 rtl/ddr_rw_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_ddr_rw_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rw_scheduler.sv
// Shares the DDR3 AXI master between write and read paths: batches same-direction
// bursts, caps a batch while the other side waits, and pads direction changes.
module ddr_rw_scheduler #(
   parameter int unsigned MAX_BATCH = 4,
   parameter int unsigned TURN_CYC  = 2,
   parameter int unsigned TIMEOUT   = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_req,
   input  logic [29:0] wr_addr,
   input  logic [7:0]  wr_len,
   input  logic        wr_done,
   input  logic        rd_req,
   input  logic [29:0] rd_addr,
   input  logic [7:0]  rd_len,
   input  logic        rd_done,
   output logic        wr_grant,
   output logic        rd_grant,
   output logic        axi_wr_start,
   output logic [29:0] axi_wr_addr,
   output logic [7:0]  axi_wr_len,
   output logic        axi_rd_start,
   output logic [29:0] axi_rd_addr,
   output logic [7:0]  axi_rd_len,
   output logic        err_timeout
);

   // state    | meaning
   // IDLE     | bus free, no direction chosen
   // WR_ISSUE | one-cycle write start
   // WR_WAIT  | write burst in flight, waiting for wr_done
   // RD_ISSUE | one-cycle read start
   // RD_WAIT  | read burst in flight, waiting for rd_done
   // TURN     | turnaround gap before serving pend_dir
   typedef enum logic [2:0] {
      S_IDLE, S_WR_ISSUE, S_WR_WAIT, S_RD_ISSUE, S_RD_WAIT, S_TURN
   } state_t;

   localparam logic        DIR_RD    = 1'b0;
   localparam bit          HAS_TURN  = (TURN_CYC != 0);
   localparam logic [3:0]  TURN_LAST = 4'(TURN_CYC - 1);
   localparam logic [4:0]  BATCH_LIM = 5'(MAX_BATCH);
   localparam logic [16:0] WAIT_LIM  = 17'(TIMEOUT);

   function automatic state_t issue_of(input logic dir);
      return dir ? S_WR_ISSUE : S_RD_ISSUE;
   endfunction

   state_t      state_q, state_d;
   logic        last_dir_q, last_dir_d;
   logic        pend_dir_q, pend_dir_d;
   logic [3:0]  batch_cnt_q, batch_cnt_d;
   logic [3:0]  turn_cnt_q, turn_cnt_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic        err_q, err_d;
   logic        wr_grant_q, wr_grant_d, rd_grant_q, rd_grant_d;
   logic        wr_start_q, wr_start_d, rd_start_q, rd_start_d;
   logic [29:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
   logic [7:0]  wr_len_q, wr_len_d, rd_len_q, rd_len_d;

   logic pick_dir, cur_dir, own_req, oth_req, own_done, pend_req;
   logic batch_hit, wait_hit, in_wait;

   always_comb begin
      state_d     = state_q;
      last_dir_d  = last_dir_q;
      pend_dir_d  = pend_dir_q;
      batch_cnt_d = batch_cnt_q;
      err_d       = err_q;
      pick_dir    = (wr_req && rd_req) ? ~last_dir_q : wr_req;
      cur_dir     = (state_q == S_WR_WAIT);
      own_req     = cur_dir ? wr_req : rd_req;
      oth_req     = cur_dir ? rd_req : wr_req;
      own_done    = cur_dir ? wr_done : rd_done;
      pend_req    = pend_dir_q ? wr_req : rd_req;
      in_wait     = (state_q == S_WR_WAIT) || (state_q == S_RD_WAIT);
      batch_hit   = ({1'b0, batch_cnt_q} + 5'd1) >= BATCH_LIM;
      wait_hit    = ({1'b0, wait_cnt_q} + 17'd1) >= WAIT_LIM;

      case (state_q)
         S_IDLE: begin
            if (wr_req || rd_req) begin
               if (HAS_TURN && (pick_dir != last_dir_q)) begin
                  state_d    = S_TURN;
                  pend_dir_d = pick_dir;
               end else begin
                  state_d = issue_of(pick_dir);
               end
            end
         end
         S_WR_ISSUE: state_d = S_WR_WAIT;
         S_RD_ISSUE: state_d = S_RD_WAIT;
         S_WR_WAIT, S_RD_WAIT: begin
            // done wins over a timeout landing on the same cycle
            if (own_done) begin
               last_dir_d = cur_dir;
               if (oth_req && (!own_req || batch_hit)) begin
                  batch_cnt_d = '0;
                  if (HAS_TURN) begin
                     state_d    = S_TURN;
                     pend_dir_d = ~cur_dir;
                  end else begin
                     state_d = issue_of(~cur_dir);
                  end
               end else if (own_req) begin
                  state_d     = issue_of(cur_dir);
                  batch_cnt_d = (batch_cnt_q == 4'hF) ? batch_cnt_q : batch_cnt_q + 4'd1;
               end else begin
                  state_d     = S_IDLE;
                  batch_cnt_d = '0;
               end
            end else if (wait_hit) begin
               err_d       = 1'b1;
               state_d     = S_IDLE;
               batch_cnt_d = '0;
               last_dir_d  = cur_dir;
            end
         end
         S_TURN: begin
            if (turn_cnt_q >= TURN_LAST)
               state_d = pend_req ? issue_of(pend_dir_q) : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      turn_cnt_d = '0;
      if ((state_q == S_TURN) && (state_d == S_TURN))
         turn_cnt_d = (turn_cnt_q == 4'hF) ? turn_cnt_q : turn_cnt_q + 4'd1;
      wait_cnt_d = '0;
      if (in_wait && (state_d == state_q))
         wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;

      wr_grant_d = (state_d == S_WR_ISSUE) || (state_d == S_WR_WAIT);
      rd_grant_d = (state_d == S_RD_ISSUE) || (state_d == S_RD_WAIT);
      wr_start_d = (state_d == S_WR_ISSUE);
      rd_start_d = (state_d == S_RD_ISSUE);
      wr_addr_d  = wr_start_d ? wr_addr : wr_addr_q;
      wr_len_d   = wr_start_d ? wr_len  : wr_len_q;
      rd_addr_d  = rd_start_d ? rd_addr : rd_addr_q;
      rd_len_d   = rd_start_d ? rd_len  : rd_len_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         last_dir_q  <= DIR_RD;
         pend_dir_q  <= DIR_RD;
         batch_cnt_q <= '0;
         turn_cnt_q  <= '0;
         wait_cnt_q  <= '0;
         err_q       <= 1'b0;
         wr_grant_q  <= 1'b0;
         rd_grant_q  <= 1'b0;
         wr_start_q  <= 1'b0;
         rd_start_q  <= 1'b0;
         wr_addr_q   <= '0;
         wr_len_q    <= '0;
         rd_addr_q   <= '0;
         rd_len_q    <= '0;
      end else begin
         state_q     <= state_d;
         last_dir_q  <= last_dir_d;
         pend_dir_q  <= pend_dir_d;
         batch_cnt_q <= batch_cnt_d;
         turn_cnt_q  <= turn_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         err_q       <= err_d;
         wr_grant_q  <= wr_grant_d;
         rd_grant_q  <= rd_grant_d;
         wr_start_q  <= wr_start_d;
         rd_start_q  <= rd_start_d;
         wr_addr_q   <= wr_addr_d;
         wr_len_q    <= wr_len_d;
         rd_addr_q   <= rd_addr_d;
         rd_len_q    <= rd_len_d;
      end
   end

   assign wr_grant     = wr_grant_q;
   assign rd_grant     = rd_grant_q;
   assign axi_wr_start = wr_start_q;
   assign axi_rd_start = rd_start_q;
   assign axi_wr_addr  = wr_addr_q;
   assign axi_wr_len   = wr_len_q;
   assign axi_rd_addr  = rd_addr_q;
   assign axi_rd_len   = rd_len_q;
   assign err_timeout  = err_q;

endmodule

// File: tb/tb_ddr_rw_scheduler.sv
// Bench for ddr_rw_scheduler: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_ddr_rw_scheduler;
   localparam int MAX_BATCH = 4;
   localparam int TURN_CYC  = 2;
   localparam int TIMEOUT   = 1023;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_req, wr_done, rd_req, rd_done;
   logic [29:0] wr_addr, rd_addr;
   logic [7:0]  wr_len, rd_len;
   logic        wr_grant, rd_grant, axi_wr_start, axi_rd_start, err_timeout;
   logic [29:0] axi_wr_addr, axi_rd_addr;
   logic [7:0]  axi_wr_len, axi_rd_len;

   int checks = 0;
   int failures = 0;

   ddr_rw_scheduler #(.MAX_BATCH(MAX_BATCH), .TURN_CYC(TURN_CYC), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_done(wr_done),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_done(rd_done),
      .wr_grant(wr_grant), .rd_grant(rd_grant),
      .axi_wr_start(axi_wr_start), .axi_wr_addr(axi_wr_addr), .axi_wr_len(axi_wr_len),
      .axi_rd_start(axi_rd_start), .axi_rd_addr(axi_rd_addr), .axi_rd_len(axi_rd_len),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [80:0] dut_out();
      return {wr_grant, rd_grant, axi_wr_start, axi_rd_start, err_timeout,
              axi_wr_addr, axi_wr_len, axi_rd_addr, axi_rd_len};
   endfunction

   // ---------------- reference model (1 = write, 2 = read, 0 = nobody) ----------------
   int          m_own, m_gap, m_pend, m_last, m_run, m_waited;
   bit          m_issue, m_err;
   logic [29:0] m_waddr, m_raddr;
   logic [7:0]  m_wlen, m_rlen;

   function automatic bit req_of(input int d);
      return (d == 1) ? wr_req : rd_req;
   endfunction

   task automatic model_reset();
      m_own = 0; m_gap = 0; m_pend = 0; m_last = 2; m_run = 0; m_waited = 0;
      m_issue = 0; m_err = 0; m_waddr = '0; m_raddr = '0; m_wlen = '0; m_rlen = '0;
   endtask

   task automatic begin_burst(input int d);
      m_own = d; m_issue = 1; m_waited = 0;
      if (d == 1) begin m_waddr = wr_addr; m_wlen = wr_len; end
      else begin m_raddr = rd_addr; m_rlen = rd_len; end
   endtask

   task automatic model_step();
      int  want, oth;
      bit  own_r, oth_r, dn;
      if (m_gap > 0) begin
         m_gap--;
         if (m_gap == 0 && req_of(m_pend)) begin_burst(m_pend);
      end else if (m_own == 0) begin
         want = (wr_req && rd_req) ? 3 - m_last : (wr_req ? 1 : (rd_req ? 2 : 0));
         if (want != 0) begin
            if (want != m_last && TURN_CYC > 0) begin m_gap = TURN_CYC; m_pend = want; end
            else begin_burst(want);
         end
      end else if (m_issue) begin
         m_issue = 0; m_waited = 0;
      end else begin
         dn = (m_own == 1) ? wr_done : rd_done;
         m_waited++;
         if (dn) begin
            oth = 3 - m_own; own_r = req_of(m_own); oth_r = req_of(oth);
            m_last = m_own; m_run++;
            if (oth_r && (!own_r || m_run >= MAX_BATCH)) begin
               m_run = 0;
               if (TURN_CYC > 0) begin m_own = 0; m_gap = TURN_CYC; m_pend = oth; end
               else begin_burst(oth);
            end else if (own_r) begin
               begin_burst(m_own);
            end else begin
               m_own = 0; m_run = 0;
            end
         end else if (m_waited >= TIMEOUT) begin
            m_err = 1; m_last = m_own; m_own = 0; m_run = 0;
         end
      end
   endtask

   function automatic logic [80:0] model_out();
      return {m_own == 1, m_own == 2, m_own == 1 && m_issue, m_own == 2 && m_issue, m_err,
              m_waddr, m_wlen, m_raddr, m_rlen};
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      logic wr, rd, wd, rdn;
      logic [29:0] wa; logic [7:0] wl; logic [29:0] ra; logic [7:0] rl;
      logic [3:0] gs;
      logic [29:0] ewa; logic [7:0] ewl; logic [29:0] era; logic [7:0] erl;
   } vec_t;
   vec_t vt [21];

   // ---------------- directed burst-pattern helper ----------------
   int st_dir[$];
   int st_gap[$];

   task automatic run_pattern(input logic w, input logic r, input int n, input string tag);
      int idle = 0;
      int cyc = 0;
      int quiet = 0;
      st_dir.delete(); st_gap.delete();
      wr_req = w; rd_req = r;
      while (st_dir.size() < n && cyc < 600) begin
         @(negedge clk); cyc++;
         wr_done = wr_grant && !axi_wr_start;
         rd_done = rd_grant && !axi_rd_start;
         if (axi_wr_start || axi_rd_start) begin
            st_dir.push_back(axi_wr_start ? 1 : 2);
            st_gap.push_back(idle);
            idle = 0;
         end else if (!wr_grant && !rd_grant) idle++;
      end
      wr_req = 0; rd_req = 0;
      chk({tag, "_count"}, st_dir.size(), n);
      while (quiet < 3 && cyc < 700) begin
         @(negedge clk); cyc++;
         wr_done = wr_grant && !axi_wr_start;
         rd_done = rd_grant && !axi_rd_start;
         quiet = (!wr_grant && !rd_grant) ? quiet + 1 : 0;
      end
      wr_done = 0; rd_done = 0;
      chk({tag, "_drain"}, {wr_grant, rd_grant}, 2'b00);
   endtask

   int k, early;

   initial begin
      vt[0]  = '{1'b1,1'b0,1'b0,1'b0, 30'h100,8'd16, 30'h0,8'd0,    4'b0000, 30'h0,8'd0,    30'h0,8'd0};
      vt[1]  = '{1'b1,1'b0,1'b0,1'b0, 30'h100,8'd16, 30'h0,8'd0,    4'b0000, 30'h0,8'd0,    30'h0,8'd0};
      vt[2]  = '{1'b1,1'b0,1'b0,1'b0, 30'h100,8'd16, 30'h0,8'd0,    4'b1010, 30'h100,8'd16, 30'h0,8'd0};
      vt[3]  = '{1'b0,1'b0,1'b0,1'b0, 30'h1FF,8'd99, 30'h0,8'd0,    4'b1000, 30'h100,8'd16, 30'h0,8'd0};
      vt[4]  = '{1'b0,1'b0,1'b1,1'b0, 30'h1FF,8'd99, 30'h0,8'd0,    4'b0000, 30'h100,8'd16, 30'h0,8'd0};
      vt[5]  = '{1'b1,1'b0,1'b0,1'b0, 30'h200,8'd8,  30'h0,8'd0,    4'b1010, 30'h200,8'd8,  30'h0,8'd0};
      vt[6]  = '{1'b0,1'b0,1'b1,1'b1, 30'h2FF,8'd9,  30'h0,8'd0,    4'b1000, 30'h200,8'd8,  30'h0,8'd0};
      vt[7]  = '{1'b0,1'b0,1'b0,1'b1, 30'h2FF,8'd9,  30'h0,8'd0,    4'b1000, 30'h200,8'd8,  30'h0,8'd0};
      vt[8]  = '{1'b0,1'b1,1'b1,1'b1, 30'h2FF,8'd9,  30'h3000,8'd4, 4'b0000, 30'h200,8'd8,  30'h0,8'd0};
      vt[9]  = '{1'b0,1'b1,1'b0,1'b0, 30'h2FF,8'd9,  30'h3000,8'd4, 4'b0000, 30'h200,8'd8,  30'h0,8'd0};
      vt[10] = '{1'b0,1'b1,1'b0,1'b0, 30'h2FF,8'd9,  30'h3000,8'd4, 4'b0101, 30'h200,8'd8,  30'h3000,8'd4};
      vt[11] = '{1'b0,1'b0,1'b0,1'b0, 30'h2FF,8'd9,  30'h3111,8'd5, 4'b0100, 30'h200,8'd8,  30'h3000,8'd4};
      vt[12] = '{1'b0,1'b0,1'b0,1'b1, 30'h2FF,8'd9,  30'h3111,8'd5, 4'b0000, 30'h200,8'd8,  30'h3000,8'd4};
      vt[13] = '{1'b1,1'b0,1'b0,1'b0, 30'h400,8'd32, 30'h3111,8'd5, 4'b0000, 30'h200,8'd8,  30'h3000,8'd4};
      vt[14] = '{1'b0,1'b0,1'b0,1'b0, 30'h400,8'd32, 30'h3111,8'd5, 4'b0000, 30'h200,8'd8,  30'h3000,8'd4};
      vt[15] = '{1'b0,1'b0,1'b0,1'b0, 30'h400,8'd32, 30'h3111,8'd5, 4'b0000, 30'h200,8'd8,  30'h3000,8'd4};
      vt[16] = '{1'b1,1'b0,1'b0,1'b0, 30'h400,8'd32, 30'h3111,8'd5, 4'b0000, 30'h200,8'd8,  30'h3000,8'd4};
      vt[17] = '{1'b1,1'b0,1'b0,1'b0, 30'h400,8'd32, 30'h3111,8'd5, 4'b0000, 30'h200,8'd8,  30'h3000,8'd4};
      vt[18] = '{1'b1,1'b0,1'b0,1'b0, 30'h400,8'd32, 30'h3111,8'd5, 4'b1010, 30'h400,8'd32, 30'h3000,8'd4};
      vt[19] = '{1'b0,1'b0,1'b0,1'b0, 30'h400,8'd32, 30'h3111,8'd5, 4'b1000, 30'h400,8'd32, 30'h3000,8'd4};
      vt[20] = '{1'b0,1'b0,1'b1,1'b0, 30'h400,8'd32, 30'h3111,8'd5, 4'b0000, 30'h400,8'd32, 30'h3000,8'd4};

      rst = 1'b1;
      wr_req = 0; rd_req = 0; wr_done = 0; rd_done = 0;
      wr_addr = '0; rd_addr = '0; wr_len = '0; rd_len = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_state", dut_out(), 81'd0);

      for (int i = 0; i < 21; i++) begin
         wr_req = vt[i].wr; rd_req = vt[i].rd; wr_done = vt[i].wd; rd_done = vt[i].rdn;
         wr_addr = vt[i].wa; wr_len = vt[i].wl; rd_addr = vt[i].ra; rd_len = vt[i].rl;
         @(negedge clk);
         chk($sformatf("vec%0d_gs", i), {wr_grant, rd_grant, axi_wr_start, axi_rd_start}, vt[i].gs);
         chk($sformatf("vec%0d_waddr", i), {axi_wr_addr, axi_wr_len}, {vt[i].ewa, vt[i].ewl});
         chk($sformatf("vec%0d_raddr", i), {axi_rd_addr, axi_rd_len}, {vt[i].era, vt[i].erl});
         chk($sformatf("vec%0d_err", i), err_timeout, 1'b0);
      end
      wr_req = 0; rd_req = 0; wr_done = 0; rd_done = 0;

      // both directions saturated: blocks of MAX_BATCH separated by TURN_CYC idle cycles
      run_pattern(1'b1, 1'b1, 16, "both");
      for (int i = 0; i < st_dir.size(); i++) begin
         chk($sformatf("both_dir%0d", i), st_dir[i], ((i / MAX_BATCH) % 2 == 0) ? 2 : 1);
         if (i > 0)
            chk($sformatf("both_gap%0d", i), st_gap[i], (i % MAX_BATCH == 0) ? TURN_CYC : 0);
      end

      // single requester is never cut off by the batch limit
      run_pattern(1'b0, 1'b1, 10, "rdonly");
      for (int i = 0; i < st_dir.size(); i++) begin
         chk($sformatf("rdonly_dir%0d", i), st_dir[i], 2);
         if (i > 0) chk($sformatf("rdonly_gap%0d", i), st_gap[i], 0);
      end

      // timeout in RD_WAIT (last direction is read, so no turnaround)
      rd_req = 1; rd_addr = 30'h777; rd_len = 8'd3;
      @(negedge clk);
      chk("to_start", axi_rd_start, 1'b1);
      rd_req = 0;
      @(negedge clk);
      k = 0; early = 0;
      while (!err_timeout && k < 1100) begin
         if (!rd_grant) early = 1;
         @(negedge clk); k++;
      end
      chk("to_cycle", k, TIMEOUT);
      chk("to_grant_held", early, 0);
      chk("to_grant_off", rd_grant, 1'b0);
      repeat (5) @(negedge clk);
      chk("to_sticky", {err_timeout, wr_grant, rd_grant}, 3'b100);

      // reset in the middle of a write burst
      wr_req = 1; wr_addr = 30'h777; wr_len = 8'd7; k = 0;
      while (!(wr_grant && !axi_wr_start) && k < 20) begin @(negedge clk); k++; end
      wr_req = 0;
      chk("rst_reach_wait", wr_grant, 1'b1);
      rst = 1'b1;
      #1;
      chk("rst_async", dut_out(), 81'd0);
      @(negedge clk);
      rst = 1'b0; wr_done = 1;
      @(negedge clk);
      wr_done = 0;
      chk("rst_done_ignored", dut_out(), 81'd0);
      wr_req = 1; wr_addr = 30'h5A5; wr_len = 8'h21;
      for (int j = 1; j <= 3; j++) begin
         @(negedge clk);
         chk($sformatf("rst_next_start%0d", j), {wr_grant, axi_wr_start}, (j == 3) ? 2'b11 : 2'b00);
      end
      chk("rst_next_addr", {axi_wr_addr, axi_wr_len}, {30'h5A5, 8'h21});
      wr_req = 0;
      @(negedge clk);
      wr_done = 1;
      @(negedge clk);
      wr_done = 0;
      chk("rst_next_idle", {wr_grant, rd_grant}, 2'b00);

      // done on the very cycle the timeout would fire wins
      rd_req = 1; k = 0;
      while (!(rd_grant && !axi_rd_start) && k < 20) begin @(negedge clk); k++; end
      rd_req = 0;
      repeat (TIMEOUT - 1) @(negedge clk);
      rd_done = 1;
      @(negedge clk);
      rd_done = 0;
      chk("to_edge_done_err", err_timeout, 1'b0);
      chk("to_edge_done_idle", {wr_grant, rd_grant}, 2'b00);

      // randomized traffic against the reference model
      rst = 1'b1;
      wr_req = 0; rd_req = 0; wr_done = 0; rd_done = 0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         chk($sformatf("rand_c%0d", c), dut_out(), model_out());
         if ($urandom_range(0, 5) == 0) wr_req = ~wr_req;
         if ($urandom_range(0, 5) == 0) rd_req = ~rd_req;
         wr_done = ($urandom_range(0, 2) == 0);
         rd_done = ($urandom_range(0, 2) == 0);
         wr_addr = 30'($urandom); wr_len = 8'($urandom);
         rd_addr = 30'($urandom); rd_len = 8'($urandom);
         model_step();
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
